// File: rtl/ls013_line_tx_pkg.sv
// Shared constants, state encoding and frame helpers for the LS013B7DH01 line transmitter.
package ls013_pkg;

  localparam int LINE_BITS    = 144;
  localparam int NUM_LINES    = 168;
  localparam int FRAME_BITS   = 176;
  localparam int TRAILER_BITS = 16;

  localparam int MODE_M0 = 0;
  localparam int MODE_M1 = 1;
  localparam int MODE_M2 = 2;

  localparam logic [7:0] MODE_WRITE = 8'h01;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } tx_state_t;

  function automatic logic [7:0] mode_byte(input logic m1);
    logic [7:0] m;
    m          = MODE_WRITE;
    m[MODE_M1] = m1;
    m[MODE_M2] = 1'b0;
    return m;
  endfunction

  function automatic logic addr_valid(input logic [7:0] addr);
    return (addr != 8'd0) && (addr <= 8'(NUM_LINES));
  endfunction

endpackage

// File: rtl/ls013_line_tx_if.sv
// Upstream request/status bundle between the frame-buffer reader and ls013_line_tx.
interface ls013_line_tx_if;
  import ls013_pkg::*;

  logic                 start;
  logic [7:0]           line_addr;
  logic [LINE_BITS-1:0] line_data;
  logic                 vcom;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport master (
    output start, line_addr, line_data, vcom,
    input  busy, done, err
  );

  modport slave (
    input  start, line_addr, line_data, vcom,
    output busy, done, err
  );

endinterface

// File: rtl/ls013_line_tx_sclk_gen.sv
// SCLK divider: low for the first half of each bit period, high for the second half,
// with strobes marking the edge at which lcd_sclk rises or falls.
module ls013_sclk_gen #(
  parameter int SCLK_DIV = 12
) (
  input  logic clk_12mhz,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int           W    = $clog2(SCLK_DIV);
  localparam logic [W-1:0] LAST = W'(SCLK_DIV - 1);
  localparam logic [W-1:0] HALF = W'(SCLK_DIV / 2);

  logic [W-1:0] div_cnt;
  logic [W-1:0] div_nxt;

  always_comb begin
    div_nxt = (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
    rise    = en && (div_cnt == HALF - 1'b1);
    fall    = en && (div_cnt == LAST);
  end

  // sclk is decoded from the next count so it is a clean flop output aligned with div_cnt
  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      sclk    <= (div_nxt >= HALF);
    end
  end

endmodule

// File: rtl/ls013_line_tx.sv
// LS013B7DH01 single-line write transmitter: mode byte, address, 144 pixels, 16-bit trailer.
// Define LS013_VCOM_TOGGLE_EN to source M1 from an internal flop that inverts after every frame.
module ls013_line_tx
  import ls013_pkg::*;
#(
  parameter int SCLK_DIV = 12,
  parameter int CS_SETUP = 72,
  parameter int CS_HOLD  = 24
) (
  input  logic              clk_12mhz,
  input  logic              rst_n,
  ls013_line_tx_if.slave    bus,
  output logic              lcd_scs,
  output logic              lcd_sclk,
  output logic              lcd_si
);

  localparam int                CNT_W      = 16;
  localparam logic [CNT_W-1:0]  SETUP_LOAD = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0]  HOLD_LOAD  = CNT_W'(CS_HOLD - 1);

  tx_state_t             state;
  logic [FRAME_BITS-1:0] sr;
  logic [7:0]            bit_cnt;
  logic [CNT_W-1:0]      cnt;
  logic                  m1;
  logic                  addr_ok;
  logic [FRAME_BITS-1:0] frame_next;
  logic                  sclk_en;
  logic                  sclk_rise;
  logic                  sclk_fall;

`ifdef LS013_VCOM_TOGGLE_EN
  logic vcom_q;
`endif

  always_comb begin
`ifdef LS013_VCOM_TOGGLE_EN
    m1 = vcom_q;
`else
    m1 = bus.vcom;
`endif
    addr_ok    = addr_valid(bus.line_addr);
    frame_next = {{TRAILER_BITS{1'b0}}, bus.line_data, bus.line_addr, mode_byte(m1)};
    sclk_en    = (state == SHIFT);
  end

  ls013_sclk_gen #(
    .SCLK_DIV (SCLK_DIV)
  ) u_sclk_gen (
    .clk_12mhz (clk_12mhz),
    .rst_n     (rst_n),
    .en        (sclk_en),
    .sclk      (lcd_sclk),
    .rise      (sclk_rise),
    .fall      (sclk_fall)
  );

  // The shift register's LSB is the SI pin, so clearing it at the end of SHIFT parks SI low
  assign lcd_si = sr[0];

  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sr       <= '0;
      bit_cnt  <= '0;
      cnt      <= '0;
      lcd_scs  <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
`ifdef LS013_VCOM_TOGGLE_EN
      vcom_q   <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      case (state)
        IDLE: begin
          // busy is still high in the done cycle, which keeps a start there from being accepted
          bus.busy <= 1'b0;
          if (bus.start && !bus.busy) begin
            if (addr_ok) begin
              sr       <= frame_next;
              bit_cnt  <= '0;
              cnt      <= SETUP_LOAD;
              lcd_scs  <= 1'b1;
              bus.busy <= 1'b1;
              state    <= SETUP;
            end else begin
              bus.err  <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            state <= SHIFT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SHIFT: begin
          if (sclk_rise) begin
            bit_cnt <= bit_cnt + 1'b1;
          end
          if (sclk_fall) begin
            if (bit_cnt == 8'(FRAME_BITS)) begin
              sr    <= '0;
              cnt   <= HOLD_LOAD;
              state <= HOLD;
            end else begin
              sr <= sr >> 1;
            end
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            lcd_scs  <= 1'b0;
            bus.done <= 1'b1;
            state    <= IDLE;
`ifdef LS013_VCOM_TOGGLE_EN
            vcom_q   <= ~vcom_q;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ls013_line_tx.sv
// Scoreboard bench for ls013_line_tx: stimulus pushes expected frames/errors, a negedge
// monitor decodes SCS/SCLK/SI and pops them on every done or err pulse.
module tb_ls013_line_tx;

  localparam int SCLK_DIV   = 12;
  localparam int CS_SETUP   = 72;
  localparam int CS_HOLD    = 24;
  localparam int NBITS      = 176;
  localparam int DONE_LAT   = CS_SETUP + NBITS * SCLK_DIV + CS_HOLD;
  localparam int NEXT_GAP   = DONE_LAT + 2;
  localparam int FIRST_RISE = CS_SETUP + SCLK_DIV / 2;

  typedef struct {
    int           acc;
    logic [175:0] frame;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic lcd_scs;
  logic lcd_sclk;
  logic lcd_si;

  ls013_line_tx_if bus ();

  ls013_line_tx #(
    .SCLK_DIV (SCLK_DIV),
    .CS_SETUP (CS_SETUP),
    .CS_HOLD  (CS_HOLD)
  ) dut (
    .clk_12mhz (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .lcd_scs   (lcd_scs),
    .lcd_sclk  (lcd_sclk),
    .lcd_si    (lcd_si)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  int   err_q[$];
  int   next_free = 0;
  int   model_frames = 0;
  int   last_acc = 0;

  task automatic checkOutput(input string name, input logic [175:0] act, input logic [175:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Reference frame assembled bit by bit in transmission order
  function automatic logic [175:0] buildFrame(input logic [7:0] addr, input logic [143:0] data,
                                              input logic m1);
    bit q[$];
    logic [175:0] f;
    q.push_back(1'b1);
    q.push_back(m1);
    repeat (6) q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(addr[i]);
    for (int i = 0; i < 144; i++) q.push_back(data[i]);
    repeat (16) q.push_back(1'b0);
    for (int i = 0; i < 176; i++) f[i] = q[i];
    return f;
  endfunction

  task automatic waitIdle();
    while (cyc + 1 < next_free) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] addr, input logic [143:0] data, input logic vc);
    int   k;
    logic m1;
    waitIdle();
    bus.start     = 1'b1;
    bus.line_addr = addr;
    bus.line_data = data;
    bus.vcom      = vc;
    k = cyc;
    if (addr >= 8'd1 && addr <= 8'd168) begin
`ifdef LS013_VCOM_TOGGLE_EN
      m1 = model_frames[0];
`else
      m1 = vc;
`endif
      exp_q.push_back('{acc: k + 1, frame: buildFrame(addr, data, m1)});
      model_frames++;
      last_acc  = k + 1;
      next_free = k + 1 + NEXT_GAP;
    end else begin
      err_q.push_back(k + 1);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic pulseWhileBusy();
    if (cyc + 2 < next_free) begin
      bus.start     = 1'b1;
      bus.line_addr = 8'd5;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
  endtask

  task automatic applyHeld(input logic [7:0] addr, input logic [143:0] data, input int n);
    int   a;
    logic m1;
    waitIdle();
    bus.start     = 1'b1;
    bus.line_addr = addr;
    bus.line_data = data;
    bus.vcom      = 1'b1;
    a = cyc + 1;
    for (int i = 0; i < n; i++) begin
`ifdef LS013_VCOM_TOGGLE_EN
      m1 = model_frames[0];
`else
      m1 = 1'b1;
`endif
      exp_q.push_back('{acc: a, frame: buildFrame(addr, data, m1)});
      model_frames++;
      last_acc = a;
      a += NEXT_GAP;
    end
    while (cyc < last_acc) begin
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    next_free = last_acc + NEXT_GAP;
  endtask

  // Monitor state
  int           nbits = 0;
  int           scs_rise_cyc = 0;
  int           first_rise_cyc = 0;
  int           last_fall_cyc = 0;
  logic [175:0] cap = '0;
  logic         prev_sclk = 1'b0;
  logic         prev_scs = 1'b0;
  bit           busy_chk = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    int   ec;
    if (!rst_n) begin
      nbits     = 0;
      prev_sclk = 1'b0;
      prev_scs  = 1'b0;
      busy_chk  = 1'b0;
    end else begin
      if (busy_chk) begin
        checkOutput("busy_after_done", 176'(bus.busy), 176'(0));
        busy_chk = 1'b0;
      end
      if (lcd_scs && !prev_scs) begin
        scs_rise_cyc   = cyc;
        nbits          = 0;
        cap            = '0;
        first_rise_cyc = -1;
        checkOutput("scs_rise_expected", 176'(exp_q.size() != 0), 176'(1));
      end
      if (lcd_sclk && !prev_sclk) begin
        if (nbits < NBITS) cap[nbits] = lcd_si;
        if (nbits == 0) first_rise_cyc = cyc;
        nbits++;
      end
      if (!lcd_sclk && prev_sclk) last_fall_cyc = cyc;
      if (bus.done) begin
        checkOutput("done_expected", 176'(exp_q.size() != 0), 176'(1));
        checkOutput("err_with_done", 176'(bus.err), 176'(0));
        checkOutput("busy_at_done", 176'(bus.busy), 176'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checkOutput("scs_rise_cycle", 176'(scs_rise_cyc), 176'(e.acc));
          checkOutput("first_sclk_rise", 176'(first_rise_cyc), 176'(e.acc + FIRST_RISE));
          checkOutput("sclk_rise_count", 176'(nbits), 176'(NBITS));
          checkOutput("frame_bits", cap, e.frame);
          checkOutput("done_cycle", 176'(cyc), 176'(e.acc + DONE_LAT));
          checkOutput("hold_cycles", 176'(cyc - last_fall_cyc), 176'(CS_HOLD));
          checkOutput("scs_low_at_done", 176'(lcd_scs), 176'(0));
        end
        busy_chk = 1'b1;
      end
      if (bus.err) begin
        checkOutput("err_expected", 176'(err_q.size() != 0), 176'(1));
        checkOutput("busy_at_err", 176'(bus.busy), 176'(0));
        checkOutput("scs_at_err", 176'(lcd_scs), 176'(0));
        if (err_q.size() != 0) begin
          ec = err_q.pop_front();
          checkOutput("err_cycle", 176'(cyc), 176'(ec));
        end
      end
      prev_sclk = lcd_sclk;
      prev_scs  = lcd_scs;
    end
  end

  initial begin
    #700000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [143:0] d;
    logic [7:0]   a;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.line_addr = '0;
    bus.line_data = '0;
    bus.vcom      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs", 176'({lcd_scs, lcd_sclk, lcd_si, bus.busy, bus.done, bus.err}), 176'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    next_free = cyc + 1;

    // Reset in the middle of SHIFT abandons the frame
    for (int i = 0; i < 144; i++) d[i] = 1'($urandom_range(0, 1));
    applyStimulus(8'd77, d, 1'b1);
    while (cyc < last_acc + 999) begin
      @(posedge clk);
      #1;
    end
    checkOutput("scs_before_reset", 176'(lcd_scs), 176'(1));
    rst_n = 1'b0;
    #1;
    checkOutput("outputs_in_reset", 176'({lcd_scs, lcd_sclk, lcd_si, bus.busy, bus.done, bus.err}), 176'(0));
    exp_q.delete();
    model_frames = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    next_free = cyc + 1;

    applyStimulus(8'd1, 144'd0, 1'b0);
    for (int i = 0; i < 144; i++) d[i] = (i % 2 == 0);
    applyStimulus(8'd168, d, 1'b1);

    applyStimulus(8'd0, d, 1'b0);
    applyStimulus(8'd169, d, 1'b1);

    for (int i = 0; i < 144; i++) d[i] = 1'($urandom_range(0, 1));
    applyHeld(8'd42, d, 3);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 144; i++) d[i] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        a = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(169, 255));
      end else begin
        a = 8'($urandom_range(1, 168));
      end
      applyStimulus(a, d, 1'($urandom_range(0, 1)));
      if (a != 8'd0 && a <= 8'd168) begin
        repeat ($urandom_range(50, 1500)) @(posedge clk);
        #1;
        pulseWhileBusy();
      end
    end

    while (cyc < next_free + 5) begin
      @(posedge clk);
      #1;
    end
    checkOutput("frames_outstanding", 176'(exp_q.size()), 176'(0));
    checkOutput("errs_outstanding", 176'(err_q.size()), 176'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
